// File: rtl/ac_motor_pkg.sv
// Shared types and defaults for the AC motor gate-drive monitor.
package ac_motor_pkg;

    localparam int DEAD_W_DEFAULT = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HIGH   = 3'd1,
        LOW    = 3'd2,
        DEAD_H = 3'd3,
        DEAD_L = 3'd4,
        FAULT  = 3'd5
    } state_t;

endpackage

// File: rtl/ac_motor_gate_monitor_if.sv
// Gate observation / result bundle between the monitor and its environment.
interface ac_motor_gate_monitor_if #(
    parameter int DEAD_W = ac_motor_pkg::DEAD_W_DEFAULT
);
    logic              ENABLE;
    logic              CLEAR;
    logic [DEAD_W-1:0] MIN_DEAD;
    logic              S_HIGH;
    logic              S_LOW;

    // DEAD_VALID is a one-cycle strobe with no back-pressure: DEAD_TIME is
    // meaningful on that cycle and simply holds afterwards until the next strobe.
    logic              S_OUT;
    logic [DEAD_W-1:0] DEAD_TIME;
    logic              DEAD_VALID;
    logic              FAULT_SHOOT;
    logic              FAULT_DEAD;
    ac_motor_pkg::state_t dbg_state;

    modport master (
        output ENABLE, CLEAR, MIN_DEAD, S_HIGH, S_LOW,
        input  S_OUT, DEAD_TIME, DEAD_VALID, FAULT_SHOOT, FAULT_DEAD, dbg_state
    );

    modport slave (
        input  ENABLE, CLEAR, MIN_DEAD, S_HIGH, S_LOW,
        output S_OUT, DEAD_TIME, DEAD_VALID, FAULT_SHOOT, FAULT_DEAD, dbg_state
    );
endinterface

// File: rtl/ac_motor_dead_counter.sv
// Saturating dead-time counter; clear wins over increment.
module ac_motor_dead_counter #(
    parameter int W = ac_motor_pkg::DEAD_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         increment,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/ac_motor_gate_monitor.sv
// Watches complementary gate drives, measures dead time between opposing
// drives and latches shoot-through / short dead-time faults.
module ac_motor_gate_monitor
    import ac_motor_pkg::*;
#(
    parameter int DEAD_W = DEAD_W_DEFAULT
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    ac_motor_gate_monitor_if.slave        bus
);
    state_t            state_q, state_d;
    logic              s_out_q, s_out_d;
    logic [DEAD_W-1:0] dead_time_q, dead_time_d;
    logic              dead_valid_q, dead_valid_d;
    logic              fault_shoot_q, fault_shoot_d;
    logic              fault_dead_q, fault_dead_d;
    logic              violation;
    logic              cnt_inc;
    logic [DEAD_W-1:0] cnt;
    logic              hi, lo;

    assign hi = bus.S_HIGH;
    assign lo = bus.S_LOW;

    ac_motor_dead_counter #(.W(DEAD_W)) u_dead_counter (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clear     (!cnt_inc),
        .increment (cnt_inc),
        .count     (cnt)
    );

    always_comb begin
        state_d       = state_q;
        dead_time_d   = dead_time_q;
        dead_valid_d  = 1'b0;
        fault_shoot_d = fault_shoot_q;
        violation     = 1'b0;
        cnt_inc       = 1'b0;

        if (bus.CLEAR && !hi && !lo) begin
            fault_shoot_d = 1'b0;
        end

        if (!bus.ENABLE) begin
            state_d = IDLE;
        end else if (hi && lo) begin
            state_d       = FAULT;
            fault_shoot_d = 1'b1;
        end else begin
            // Count is 0 outside the dead states, so entering DEAD_x loads 1.
            unique case (state_q)
                IDLE: begin
                    if (hi)      state_d = HIGH;
                    else if (lo) state_d = LOW;
                end
                HIGH: begin
                    if (lo) begin
                        state_d      = LOW;
                        dead_time_d  = '0;
                        dead_valid_d = 1'b1;
                        violation    = 1'b1;
                    end else if (!hi) begin
                        state_d = DEAD_H;
                        cnt_inc = 1'b1;
                    end
                end
                DEAD_H: begin
                    if (lo) begin
                        state_d      = LOW;
                        dead_time_d  = cnt;
                        dead_valid_d = 1'b1;
                        violation    = (cnt < bus.MIN_DEAD);
                    end else if (hi) begin
                        state_d = HIGH;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                LOW: begin
                    if (hi) begin
                        state_d      = HIGH;
                        dead_time_d  = '0;
                        dead_valid_d = 1'b1;
                        violation    = 1'b1;
                    end else if (!lo) begin
                        state_d = DEAD_L;
                        cnt_inc = 1'b1;
                    end
                end
                DEAD_L: begin
                    if (hi) begin
                        state_d      = HIGH;
                        dead_time_d  = cnt;
                        dead_valid_d = 1'b1;
                        violation    = (cnt < bus.MIN_DEAD);
                    end else if (lo) begin
                        state_d = LOW;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                FAULT: begin
                    if (bus.CLEAR && !hi && !lo) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        fault_dead_d = violation | (fault_dead_q & ~bus.CLEAR);
        s_out_d      = (state_d == HIGH) || (state_d == DEAD_H);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            s_out_q       <= 1'b0;
            dead_time_q   <= '0;
            dead_valid_q  <= 1'b0;
            fault_shoot_q <= 1'b0;
            fault_dead_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_out_q       <= s_out_d;
            dead_time_q   <= dead_time_d;
            dead_valid_q  <= dead_valid_d;
            fault_shoot_q <= fault_shoot_d;
            fault_dead_q  <= fault_dead_d;
        end
    end

    assign bus.S_OUT       = s_out_q;
    assign bus.DEAD_TIME   = dead_time_q;
    assign bus.DEAD_VALID  = dead_valid_q;
    assign bus.FAULT_SHOOT = fault_shoot_q;
    assign bus.FAULT_DEAD  = fault_dead_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_ac_motor_gate_monitor.sv
// Bench for the gate monitor: directed vector table, corner sequences and a
// randomized run against a drive/gap reference model.
module tb_ac_motor_gate_monitor;
    import ac_motor_pkg::*;

    localparam int W    = 11;
    localparam int MAXV = (1 << W) - 1;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    ac_motor_gate_monitor_if #(.DEAD_W(W)) bus ();

    ac_motor_gate_monitor #(.DEAD_W(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: last side driven (0 none, 1 high, 2 low), gap length,
    // fault flag, plus the expected outputs.
    int m_side;
    int m_gap;
    bit m_fault;
    bit e_sout, e_valid, e_shoot, e_fd;
    int e_dt;

    typedef struct {
        logic         en, clr, hi, lo;
        logic [W-1:0] md;
        logic         sout, valid;
        logic [W-1:0] dt;
        logic         shoot, fd;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit en, bit clr, bit hi, bit lo, int md,
                                bit sout, bit valid, int dt, bit shoot, bit fd);
        vec_t v;
        v.en = en; v.clr = clr; v.hi = hi; v.lo = lo; v.md = W'(md);
        v.sout = sout; v.valid = valid; v.dt = W'(dt); v.shoot = shoot; v.fd = fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit hi, lo, viol;
        int cur, meas;
        hi = bus.S_HIGH;
        lo = bus.S_LOW;
        viol = 1'b0;
        e_valid = 1'b0;
        if (!RST_N) begin
            m_fault = 0; m_side = 0; m_gap = 0;
            e_dt = 0; e_shoot = 0; e_fd = 0; e_sout = 0;
            return;
        end
        if (bus.CLEAR && !hi && !lo) e_shoot = 0;
        if (!bus.ENABLE) begin
            m_fault = 0; m_side = 0; m_gap = 0;
        end else if (hi && lo) begin
            m_fault = 1; e_shoot = 1; m_side = 0; m_gap = 0;
        end else if (m_fault) begin
            if (bus.CLEAR && !hi && !lo) begin
                m_fault = 0; m_side = 0; m_gap = 0;
            end
        end else begin
            cur = hi ? 1 : (lo ? 2 : 0);
            if (cur == 0) begin
                if (m_side != 0) m_gap++;
            end else begin
                if (m_side != 0 && cur != m_side) begin
                    meas    = (m_gap > MAXV) ? MAXV : m_gap;
                    e_dt    = meas;
                    e_valid = 1;
                    viol    = (meas == 0) || (meas < int'(bus.MIN_DEAD));
                end
                m_side = cur;
                m_gap  = 0;
            end
        end
        e_fd   = viol | (e_fd & !bus.CLEAR);
        e_sout = !m_fault && (m_side == 1);
    endtask

    task automatic apply(input logic en, input logic clr, input logic hi, input logic lo,
                         input logic [W-1:0] md);
        bus.ENABLE   = en;
        bus.CLEAR    = clr;
        bus.S_HIGH   = hi;
        bus.S_LOW    = lo;
        bus.MIN_DEAD = md;
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_sout"},  32'(bus.S_OUT),       32'(e_sout));
        chk({tag, "_valid"}, 32'(bus.DEAD_VALID),  32'(e_valid));
        chk({tag, "_dt"},    32'(bus.DEAD_TIME),   e_dt);
        chk({tag, "_shoot"}, 32'(bus.FAULT_SHOOT), 32'(e_shoot));
        chk({tag, "_fdead"}, 32'(bus.FAULT_DEAD),  32'(e_fd));
    endtask

    task automatic step(input string tag, input logic en, input logic clr,
                        input logic hi, input logic lo, input logic [W-1:0] md);
        apply(en, clr, hi, lo, md);
        cmp_model(tag);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step("rst", 1'b1, 1'b0, 1'b0, 1'b0, W'(0));
        RST_N = 1'b1;
    endtask

    initial begin
        logic [W-1:0] rmd;
        int r;
        logic rhi, rlo;

        bus.ENABLE = 1'b0; bus.CLEAR = 1'b0; bus.S_HIGH = 1'b0; bus.S_LOW = 1'b0;
        bus.MIN_DEAD = '0;

        // Clock/reset and reset-state check, with gates driven high during reset.
        RST_N = 1'b0;
        step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, W'(5));
        chk("rst0_state", 32'(bus.dbg_state), 32'(IDLE));
        RST_N = 1'b1;

        // Directed table: 5-gap measurement, zero-gap switch, shoot-through, clear.
        tbl[0]  = mk(1,0,1,0,3, 1,0,0,0,0);
        tbl[1]  = mk(1,0,0,0,3, 1,0,0,0,0);
        tbl[2]  = mk(1,0,0,0,3, 1,0,0,0,0);
        tbl[3]  = mk(1,0,0,0,3, 1,0,0,0,0);
        tbl[4]  = mk(1,0,0,0,3, 1,0,0,0,0);
        tbl[5]  = mk(1,0,0,0,3, 1,0,0,0,0);
        tbl[6]  = mk(1,0,0,1,3, 0,1,5,0,0);
        tbl[7]  = mk(1,0,0,1,3, 0,0,5,0,0);
        tbl[8]  = mk(1,0,1,0,3, 1,1,0,0,1);
        tbl[9]  = mk(1,1,1,0,3, 1,0,0,0,0);
        tbl[10] = mk(1,0,1,1,3, 0,0,0,1,0);
        tbl[11] = mk(1,1,1,0,3, 0,0,0,1,0);
        tbl[12] = mk(1,1,0,0,3, 0,0,0,0,0);
        tbl[13] = mk(1,0,0,1,3, 0,0,0,0,0);
        tbl[14] = mk(1,0,0,0,3, 0,0,0,0,0);
        tbl[15] = mk(1,0,0,0,3, 0,0,0,0,0);
        tbl[16] = mk(1,0,0,0,3, 0,0,0,0,0);
        tbl[17] = mk(1,0,1,0,3, 1,1,3,0,0);
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].en, tbl[i].clr, tbl[i].hi, tbl[i].lo, tbl[i].md);
            chk($sformatf("tbl%0d_sout", i),  32'(bus.S_OUT),       32'(tbl[i].sout));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.DEAD_VALID),  32'(tbl[i].valid));
            chk($sformatf("tbl%0d_dt", i),    32'(bus.DEAD_TIME),   32'(tbl[i].dt));
            chk($sformatf("tbl%0d_shoot", i), 32'(bus.FAULT_SHOOT), 32'(tbl[i].shoot));
            chk($sformatf("tbl%0d_fdead", i), 32'(bus.FAULT_DEAD),  32'(tbl[i].fd));
        end

        // Short gap LOW->HIGH against MIN_DEAD=8: sticky until CLEAR.
        do_reset();
        step("g4", 1, 0, 0, 1, W'(8));
        for (int i = 0; i < 4; i++) step("g4", 1, 0, 0, 0, W'(8));
        step("g4", 1, 0, 1, 0, W'(8));
        chk("g4_dt", 32'(bus.DEAD_TIME), 32'd4);
        chk("g4_fdead", 32'(bus.FAULT_DEAD), 32'd1);
        for (int i = 0; i < 3; i++) step("g4hold", 1, 0, 1, 0, W'(8));
        chk("g4_sticky", 32'(bus.FAULT_DEAD), 32'd1);
        step("g4clr", 1, 1, 1, 0, W'(8));
        chk("g4_cleared", 32'(bus.FAULT_DEAD), 32'd0);
        // New violation in the same cycle as CLEAR wins.
        step("clrviol", 1, 1, 0, 1, W'(8));
        chk("clrviol_fdead", 32'(bus.FAULT_DEAD), 32'd1);

        // ENABLE low forces IDLE but keeps DEAD_TIME and faults.
        step("en", 1, 0, 1, 0, W'(0));
        step("en_off", 0, 0, 1, 0, W'(0));
        chk("en_off_sout", 32'(bus.S_OUT), 32'd0);
        chk("en_off_fdead", 32'(bus.FAULT_DEAD), 32'd1);
        chk("en_off_state", 32'(bus.dbg_state), 32'(IDLE));
        step("en_on", 1, 0, 0, 1, W'(0));
        chk("en_on_valid", 32'(bus.DEAD_VALID), 32'd0);

        // Aborted transition: HIGH, 3 idle, HIGH again.
        do_reset();
        step("ab", 1, 0, 1, 0, W'(0));
        step("ab", 1, 0, 0, 0, W'(0));
        step("ab", 1, 0, 0, 1, W'(0));
        step("ab", 1, 0, 0, 0, W'(0));
        step("ab", 1, 0, 1, 0, W'(0));
        for (int i = 0; i < 3; i++) step("ab_gap", 1, 0, 0, 0, W'(0));
        step("ab_back", 1, 0, 1, 0, W'(0));
        chk("ab_valid", 32'(bus.DEAD_VALID), 32'd0);
        chk("ab_dt", 32'(bus.DEAD_TIME), 32'd1);
        chk("ab_sout", 32'(bus.S_OUT), 32'd1);

        // Saturation: 3000-cycle gap.
        do_reset();
        step("sat", 1, 0, 1, 0, W'(0));
        for (int i = 0; i < 3000; i++) apply(1, 0, 0, 0, W'(0));
        step("sat", 1, 0, 0, 1, W'(0));
        chk("sat_dt", 32'(bus.DEAD_TIME), 32'd2047);
        chk("sat_valid", 32'(bus.DEAD_VALID), 32'd1);

        // Reset asserted in DEAD_L with count 7, then LOW is a fresh first edge.
        do_reset();
        step("rdl", 1, 0, 1, 0, W'(0));
        step("rdl", 1, 0, 0, 0, W'(0));
        step("rdl", 1, 0, 0, 1, W'(0));
        for (int i = 0; i < 7; i++) step("rdl", 1, 0, 0, 0, W'(0));
        RST_N = 1'b0;
        step("rdl_rst", 1, 0, 0, 0, W'(0));
        chk("rdl_dt", 32'(bus.DEAD_TIME), 32'd0);
        chk("rdl_state", 32'(bus.dbg_state), 32'(IDLE));
        RST_N = 1'b1;
        step("rdl_first", 1, 0, 0, 1, W'(0));
        chk("rdl_first_valid", 32'(bus.DEAD_VALID), 32'd0);
        step("rdl_after", 1, 0, 0, 0, W'(0));
        step("rdl_after", 1, 0, 1, 0, W'(0));
        chk("rdl_after_dt", 32'(bus.DEAD_TIME), 32'd1);

        // Randomized run against the reference model.
        do_reset();
        rmd = W'($urandom_range(0, 6));
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rmd = W'($urandom_range(0, 6));
            r = $urandom_range(0, 99);
            rhi = (r < 2) || (r >= 40 && r < 70);
            rlo = (r < 2) || (r >= 70);
            step("rnd", ($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
                 rhi, rlo, rmd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ac_motor_gate_monitor.md
AC_MOTOR_GATE_MONITOR -- requirements
Module: ac_motor_gate_monitor

Interface
REQ-001 The block SHALL have parameter DEAD_W, default 11, setting the dead-time counter and measurement width.
REQ-002 Port CLK input 1: single system clock; all logic on rising edge.
REQ-003 Port RST_N input 1: reset, synchronous, active-low.
REQ-004 Port ENABLE input 1: monitor enable; low forces IDLE.
REQ-005 Port CLEAR input 1: clears latched faults.
REQ-006 Port MIN_DEAD input DEAD_W: minimum legal dead time in CLK cycles.
REQ-007 Port S_HIGH input 1: observed high-side gate drive, synchronous to CLK.
REQ-008 Port S_LOW input 1: observed low-side gate drive, synchronous to CLK.
REQ-009 Port S_OUT output 1: reconstructed switch command, i.e. the last side driven.
REQ-010 Port DEAD_TIME output DEAD_W: last measured dead-time length in cycles.
REQ-011 Port DEAD_VALID output 1: one-cycle strobe when DEAD_TIME updates.
REQ-012 Port FAULT_SHOOT output 1: latched shoot-through fault.
REQ-013 Port FAULT_DEAD output 1: latched dead-time violation.

Function
REQ-014 All outputs SHALL be registered, responding one cycle after the input sample causing them.
REQ-015 The FSM SHALL have states IDLE, HIGH, LOW, DEAD_H (dead after high), DEAD_L (dead after low) and FAULT.
REQ-016 In any state with ENABLE=1, a sample with S_HIGH=S_LOW=1 SHALL enter FAULT and set FAULT_SHOOT; this has priority over every other event, including CLEAR.
REQ-017 IDLE transitions: (1,0)->HIGH; (0,1)->LOW; (0,0) stays; no measurement is made on this first edge.
REQ-018 HIGH transitions: (1,0) stays; (0,0)->DEAD_H with counter=1; (0,1)->LOW, DEAD_TIME=0, DEAD_VALID pulse, FAULT_DEAD set.
REQ-019 DEAD_H transitions: (0,0) counter+1, saturating at 2^DEAD_W-1; (0,1)->LOW with DEAD_TIME=counter and a DEAD_VALID pulse, setting FAULT_DEAD if counter<MIN_DEAD; (1,0)->HIGH as an aborted transition, with no measurement, no strobe and the counter cleared.
REQ-020 LOW and DEAD_L SHALL behave as REQ-018/019 with the roles of S_HIGH/S_LOW and HIGH/LOW swapped.
REQ-021 Measured DEAD_TIME SHALL equal the number of consecutive (0,0) samples between opposing drives; MIN_DEAD=0 disables the FAULT_DEAD check except for the zero-gap case in REQ-018.
REQ-022 S_OUT SHALL be 1 in HIGH and DEAD_H, and 0 in LOW, DEAD_L, IDLE and FAULT.
REQ-023 FAULT SHALL persist until a cycle with CLEAR=1 and S_HIGH=S_LOW=0, which SHALL return the FSM to IDLE and clear FAULT_SHOOT.
REQ-024 FAULT_DEAD SHALL be sticky and clear only on CLEAR=1; if a new violation occurs in the same cycle as CLEAR, FAULT_DEAD SHALL be set.
REQ-025 ENABLE=0 SHALL force IDLE, clear the counter and force S_OUT=0 and DEAD_VALID=0, while retaining DEAD_TIME and the fault flags.
REQ-026 DEAD_TIME SHALL hold its value between strobes.

Reset
REQ-027 When RST_N=0 at a clock edge, the block SHALL enter IDLE and clear the counter, S_OUT, DEAD_TIME, DEAD_VALID, FAULT_SHOOT and FAULT_DEAD to 0.
REQ-028 Reset SHALL override ENABLE, CLEAR and all gate inputs, including when asserted mid-dead-time or in FAULT.

Structure
REQ-029 The FSM state encoding and the DEAD_W default SHALL reside in shared package ac_motor_pkg.
REQ-030 The saturating dead-time counter SHALL be a sub-module, ac_motor_dead_counter, with inputs clear/increment and a saturated count output.

Verification
REQ-031 Scenario: HIGH, then 5 cycles of (0,0), then LOW with MIN_DEAD=3 -> DEAD_TIME=5, one DEAD_VALID pulse, FAULT_DEAD=0, and S_OUT falls one cycle after LOW is sampled.
REQ-032 Scenario: MIN_DEAD=8 with a 4-cycle gap from LOW to HIGH -> DEAD_TIME=4, FAULT_DEAD=1 and sticky; FAULT_DEAD remains 1 until CLEAR.
REQ-033 Scenario: (1,1) for 1 cycle during HIGH -> FAULT with FAULT_SHOOT=1 and S_OUT=0; CLEAR with (1,0) stays in FAULT; CLEAR with (0,0) returns to IDLE with FAULT_SHOOT=0.
REQ-034 Scenario: HIGH, 3 cycles of (0,0), then HIGH again -> no DEAD_VALID, DEAD_TIME unchanged, S_OUT stays 1.
REQ-035 Scenario: DEAD_W=11 with a 3000-cycle gap -> DEAD_TIME=2047.
REQ-036 Scenario: RST_N=0 asserted in DEAD_L at counter=7 -> all outputs 0 next cycle; a subsequent LOW sample after reset is treated as an IDLE first edge with no strobe.
